// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache port between the load path and ROB-committed stores, one access at a time.
// Build macro DCARB_STORE_PRIO_EN: when defined, stores always win ties; otherwise ties alternate round-robin.
module dcache_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_mbe,
  output logic        st_ack,
  output logic        mem_read_d,
  output logic        mem_write_d,
  output logic [31:0] mem_address_d,
  output logic [31:0] mem_wdata_d,
  output logic [3:0]  mem_byte_enable_d,
  input  logic        mem_resp_d,
  input  logic [31:0] mem_rdata_d
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    GNT_LOAD  = 1'b0,
    GNT_STORE = 1'b1
  } grant_e;

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mbe_q, mbe_d;

  logic        ld_elig;
  logic        st_elig;
  logic        tie_store;
  logic        pick_store;
  logic        grant_ld;
  logic        grant_st;

`ifdef DCARB_STORE_PRIO_EN
  assign tie_store = 1'b1;
`else
  grant_e last_grant_q, last_grant_d;

  // The side that was not served last wins the next tie.
  assign tie_store = (last_grant_q == GNT_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GNT_LOAD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_st) begin
      last_grant_d = GNT_STORE;
    end else if (grant_ld) begin
      last_grant_d = GNT_LOAD;
    end else begin
      last_grant_d = last_grant_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      mbe_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mbe_d      = mbe_q;
    ld_resp    = 1'b0;
    st_ack     = 1'b0;
    grant_ld   = 1'b0;
    grant_st   = 1'b0;
    pick_store = 1'b0;
    ld_elig    = ld_req & ~flush;
    st_elig    = st_req;

    case (state_q)
      IDLE: begin
        if (ld_elig && st_elig) begin
          pick_store = tie_store;
        end else begin
          pick_store = st_elig;
        end

        if (pick_store) begin
          grant_st = 1'b1;
          state_d  = STORE;
          wr_d     = 1'b1;
          addr_d   = st_addr;
          wdata_d  = st_wdata;
          mbe_d    = st_mbe;
        end else if (ld_elig) begin
          grant_ld = 1'b1;
          state_d  = LOAD;
          rd_d     = 1'b1;
          addr_d   = ld_addr;
          mbe_d    = 4'b0000;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        if (mem_resp_d) begin
          ld_resp = ~flush;
          state_d = IDLE;
          rd_d    = 1'b0;
          mbe_d   = 4'b0000;
        end else if (flush) begin
          state_d = DRAIN;
        end else begin
          state_d = LOAD;
        end
      end

      // A squashed read still runs to completion so the cache never sees a dropped strobe.
      DRAIN: begin
        if (mem_resp_d) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          mbe_d   = 4'b0000;
        end else begin
          state_d = DRAIN;
        end
      end

      STORE: begin
        if (mem_resp_d) begin
          st_ack  = 1'b1;
          state_d = IDLE;
          wr_d    = 1'b0;
          mbe_d   = 4'b0000;
        end else begin
          state_d = STORE;
        end
      end

      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        mbe_d   = 4'b0000;
      end
    endcase
  end

  assign mem_read_d        = rd_q;
  assign mem_write_d       = wr_q;
  assign mem_address_d     = addr_q;
  assign mem_wdata_d       = wdata_q;
  assign mem_byte_enable_d = mbe_q;
  assign ld_rdata          = mem_rdata_d;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: transaction-level reference model, directed scenarios, then random traffic.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        ld_req, st_req;
  logic [31:0] ld_addr, st_addr, st_wdata;
  logic [3:0]  st_mbe;
  logic        mem_resp_d;
  logic [31:0] mem_rdata_d;
  logic        ld_resp, st_ack, mem_read_d, mem_write_d;
  logic [31:0] ld_rdata, mem_address_d, mem_wdata_d;
  logic [3:0]  mem_byte_enable_d;

  always #5 clk = ~clk;

  dcache_port_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_resp(ld_resp), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_mbe(st_mbe), .st_ack(st_ack),
    .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .mem_address_d(mem_address_d),
    .mem_wdata_d(mem_wdata_d), .mem_byte_enable_d(mem_byte_enable_d),
    .mem_resp_d(mem_resp_d), .mem_rdata_d(mem_rdata_d)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one outstanding transaction record plus whose turn a tie is.
  bit          m_busy, m_is_st, m_killed, m_last_st;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mbe;
  int          lat_cnt, next_lat;
  bit          rand_lat;
  bit          rdata_fix;
  logic [31:0] rdata_val;
  bit          grant_log[$];
  bit          dut_log[$];

  bit          last_ldr, last_sta, last_mresp, last_flush, prev_strobe;
  int          obs_rd, obs_wr, obs_ldr, obs_sta;
  logic [31:0] obs_rdata, obs_raddr, obs_waddr, obs_wdata;
  logic [3:0]  obs_mbe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_obs();
    obs_rd = 0; obs_wr = 0; obs_ldr = 0; obs_sta = 0;
  endtask

  // One clock cycle: drive the cache, compare mid-cycle, then advance the model at the edge.
  task automatic step();
    bit e_rd, e_wr, e_ldr, e_sta, ld_el, st_el, pick_st;
    logic [3:0] e_mbe;
    mem_resp_d  = m_busy && (lat_cnt == 0);
    mem_rdata_d = rdata_fix ? rdata_val : $urandom;
    #3;
    e_rd  = m_busy && !m_is_st;
    e_wr  = m_busy && m_is_st;
    e_mbe = e_wr ? m_mbe : 4'b0000;
    e_ldr = e_rd && !m_killed && mem_resp_d && !flush;
    e_sta = e_wr && mem_resp_d;
    chk("mem_read_d", {31'd0, mem_read_d}, {31'd0, e_rd});
    chk("mem_write_d", {31'd0, mem_write_d}, {31'd0, e_wr});
    chk("mem_address_d", mem_address_d, m_addr);
    chk("mem_wdata_d", mem_wdata_d, m_wdata);
    chk("mem_byte_enable_d", {28'd0, mem_byte_enable_d}, {28'd0, e_mbe});
    chk("ld_resp", {31'd0, ld_resp}, {31'd0, e_ldr});
    chk("st_ack", {31'd0, st_ack}, {31'd0, e_sta});
    if (e_ldr) chk("ld_rdata", ld_rdata, mem_rdata_d);

    obs_rd += int'(mem_read_d);
    obs_wr += int'(mem_write_d);
    if (ld_resp) begin obs_ldr++; obs_rdata = ld_rdata; end
    if (st_ack) obs_sta++;
    if (mem_read_d) obs_raddr = mem_address_d;
    if (mem_write_d) begin obs_waddr = mem_address_d; obs_wdata = mem_wdata_d; obs_mbe = mem_byte_enable_d; end
    if ((mem_read_d || mem_write_d) && !prev_strobe) dut_log.push_back(mem_write_d);
    prev_strobe = mem_read_d || mem_write_d;

    last_ldr = e_ldr; last_sta = e_sta; last_mresp = mem_resp_d; last_flush = flush;

    if (rst) begin
      m_busy = 1'b0; m_last_st = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_mbe = 4'h0;
    end else if (!m_busy) begin
      ld_el = ld_req && !flush;
      st_el = st_req;
`ifdef DCARB_STORE_PRIO_EN
      pick_st = st_el;
`else
      pick_st = (ld_el && st_el) ? !m_last_st : st_el;
`endif
      if (ld_el || st_el) begin
        m_busy = 1'b1; m_is_st = pick_st; m_killed = 1'b0; m_last_st = pick_st;
        m_addr = pick_st ? st_addr : ld_addr;
        if (pick_st) begin m_wdata = st_wdata; m_mbe = st_mbe; end
        lat_cnt = rand_lat ? int'($urandom_range(0, 3)) : next_lat;
        grant_log.push_back(pick_st);
      end
    end else if (mem_resp_d) begin
      m_busy = 1'b0;
    end else begin
      lat_cnt--;
      if (!m_is_st && flush) m_killed = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; flush = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

  initial begin
    int n, nld, nst;
    rst = 1'b1; flush = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    ld_addr = 32'h0; st_addr = 32'h0; st_wdata = 32'h0; st_mbe = 4'h0;
    mem_resp_d = 1'b0; mem_rdata_d = 32'h0;
    m_busy = 1'b0; m_is_st = 1'b0; m_killed = 1'b0; m_last_st = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_mbe = 4'h0;
    lat_cnt = 0; next_lat = 0; rand_lat = 1'b0; rdata_fix = 1'b0; rdata_val = 32'h0;
    prev_strobe = 1'b0;
    @(posedge clk);
    #1;

    // Reset then idle for 10 cycles.
    reset_dut();
    clear_obs();
    for (int i = 0; i < 10; i++) step();
    chk("idle_activity", obs_rd + obs_wr + obs_ldr + obs_sta, 0);

    // Load with three strobe cycles.
    next_lat = 2; rdata_fix = 1'b1; rdata_val = 32'hDEAD_BEEF; clear_obs();
    ld_addr = 32'h0000_1004; ld_req = 1'b1;
    n = 0;
    while (!last_ldr && n < 12) begin step(); n++; end
    ld_req = 1'b0; rdata_fix = 1'b0;
    step();
    chk("load_cycles_to_resp", n, 4);
    chk("load_read_cycles", obs_rd, 3);
    chk("load_resp_pulses", obs_ldr, 1);
    chk("load_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk("load_addr", obs_raddr, 32'h0000_1004);
    chk("load_no_write", obs_wr, 0);

    // Minimum-latency load.
    next_lat = 0; ld_addr = 32'h0000_0040; ld_req = 1'b1; n = 0;
    while (!last_ldr && n < 12) begin step(); n++; end
    ld_req = 1'b0;
    step();
    chk("load_min_latency", n, 2);

    // Store with a flush in the middle.
    next_lat = 3; clear_obs();
    st_addr = 32'h0000_2000; st_wdata = 32'h0000_00AB; st_mbe = 4'b0001; st_req = 1'b1;
    n = 0;
    while (!last_sta && n < 12) begin
      flush = (n == 2);
      step();
      n++;
    end
    st_req = 1'b0; flush = 1'b0;
    step();
    chk("store_write_cycles", obs_wr, 4);
    chk("store_ack_pulses", obs_sta, 1);
    chk("store_addr", obs_waddr, 32'h0000_2000);
    chk("store_wdata", obs_wdata, 32'h0000_00AB);
    chk("store_mbe", {28'd0, obs_mbe}, 32'd1);
    chk("store_no_read", obs_rd, 0);

    // Both requesters held for four transactions.
    reset_dut();
    next_lat = 1; grant_log.delete(); dut_log.delete();
    ld_addr = 32'h0000_3000; ld_req = 1'b1;
    st_addr = 32'h0000_4000; st_wdata = 32'h5555_AAAA; st_mbe = 4'hF; st_req = 1'b1;
    nld = 0; nst = 0;
    for (int i = 0; i < 40 && (nld < 2 || nst < 2); i++) begin
      step();
      if (last_ldr) begin nld++; ld_addr = ld_addr + 32'd4; if (nld == 2) ld_req = 1'b0; end
      if (last_sta) begin nst++; st_addr = st_addr + 32'd4; if (nst == 2) st_req = 1'b0; end
    end
    step();
    chk("tie_loads_done", nld, 2);
    chk("tie_stores_done", nst, 2);
    chk("tie_dut_grants", dut_log.size(), 4);
    chk("tie_model_grants", grant_log.size(), 4);
    if (dut_log.size() == 4 && grant_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
`ifdef DCARB_STORE_PRIO_EN
        chk($sformatf("tie_dut_grant%0d", i), {31'd0, dut_log[i]}, {31'd0, (i < 2)});
        chk($sformatf("tie_model_grant%0d", i), {31'd0, grant_log[i]}, {31'd0, (i < 2)});
`else
        chk($sformatf("tie_dut_grant%0d", i), {31'd0, dut_log[i]}, {31'd0, (i % 2 == 0)});
        chk($sformatf("tie_model_grant%0d", i), {31'd0, grant_log[i]}, {31'd0, (i % 2 == 0)});
`endif
      end
    end

    // Flush two cycles into a load; cache answers three cycles later.
    next_lat = 4; clear_obs();
    ld_addr = 32'h0000_5000; ld_req = 1'b1;
    step();
    step();
    st_addr = 32'h0000_6000; st_wdata = 32'h1234_5678; st_mbe = 4'b1100; st_req = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; ld_req = 1'b0; n = 0;
    while (!last_mresp && n < 12) begin step(); n++; end
    chk("drain_read_cycles", obs_rd, 5);
    chk("drain_no_resp", obs_ldr, 0);
    next_lat = 0; obs_wr = 0;
    step();
    step();
    st_req = 1'b0;
    chk("drain_then_store", obs_wr, 1);
    chk("drain_store_ack", obs_sta, 1);

    // Flush coinciding with a new load request in IDLE.
    step(); clear_obs();
    ld_addr = 32'h0000_7000; ld_req = 1'b1; flush = 1'b1;
    step();
    ld_req = 1'b0; flush = 1'b0;
    step();
    chk("flush_blocks_load", obs_rd, 0);

    // Random traffic.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (ld_req && (last_ldr || last_flush)) ld_req = 1'b0;
      else if (!ld_req && $urandom_range(0, 2) == 0) begin ld_req = 1'b1; ld_addr = $urandom; end
      if (st_req && last_sta) st_req = 1'b0;
      else if (!st_req && $urandom_range(0, 2) == 0) begin
        st_req = 1'b1; st_addr = $urandom; st_wdata = $urandom; st_mbe = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
